// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for the VGA pixel clock domain.
// Produces scan coordinates, display enable, latency-matched syncs,
// a per-frame pulse and a frame counter.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE     = 640,
  parameter int unsigned H_FRONT       = 16,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BACK        = 48,
  parameter int unsigned V_VISIBLE     = 480,
  parameter int unsigned V_FRONT       = 10,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BACK        = 33,
  parameter int unsigned PIXEL_LATENCY = 2
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        blank_d,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);

  // Decode bounds kept 11 bits wide so a sync ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_VIS   = 11'(H_VISIBLE);
  localparam logic [10:0] HS_BEG  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS   = 11'(V_VISIBLE);
  localparam logic [10:0] VS_BEG  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic [10:0] h_ext, v_ext;
  logic        hs_raw, vs_raw;
  logic [2:0]  raw_bits;

  // Next-state for the raster counters and the completed-frame count
  always_comb begin
    h_d         = h_q + 10'd1;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d         = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        v_d = v_q + 10'd1;
      end
    end
  end

  // Counter registers; reset returns scanning to (0,0) with no frame credit
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q         <= '0;
      v_q         <= '0;
      frame_cnt_q <= '0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign h_ext    = {1'b0, h_q};
  assign v_ext    = {1'b0, v_q};

  assign blank    = (h_ext < H_VIS) && (v_ext < V_VIS);
  assign hs_raw   = !((h_ext >= HS_BEG) && (h_ext < HS_END));
  assign vs_raw   = !((v_ext >= VS_BEG) && (v_ext < VS_END));
  assign raw_bits = {hs_raw, vs_raw, blank};

  assign DrawX       = h_q;
  assign DrawY       = v_q;
  assign frame_count = frame_cnt_q;
  assign frame_start = (h_q == '0) && (v_q == '0) && reset_n;

  generate
    if (PIXEL_LATENCY == 0) begin : g_no_delay
      assign {hs, vs, blank_d} = raw_bits;
    end else begin : g_delay
      // Stage k occupies bits [3k+2:3k]; each stage is {hs, vs, blank}
      logic [3*PIXEL_LATENCY-1:0] pipe_q;
      logic [3*PIXEL_LATENCY+2:0] pipe_cat;

      assign pipe_cat = {pipe_q, raw_bits};

      // Sync/enable delay line; idle state is syncs inactive, display off
      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          pipe_q <= {PIXEL_LATENCY{3'b110}};
        end else begin
          pipe_q <= pipe_cat[3*PIXEL_LATENCY-1:0];
        end
      end

      assign {hs, vs, blank_d} = pipe_q[3*PIXEL_LATENCY-1 -: 3];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: compares five timing generators (four compact rasters
// at latencies 0/1/2/7 and one at default VGA timing) against a time-based
// reference model, with randomized reset placement and a frame-counter preload.
module tb_vga_timing_gen;

  localparam int SHV = 10;
  localparam int SHF = 2;
  localparam int SHS = 3;
  localparam int SHB = 2;
  localparam int SVV = 6;
  localparam int SVF = 1;
  localparam int SVS = 2;
  localparam int SVB = 2;
  localparam int NI  = 5;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  dx  [NI];
  logic [9:0]  dy  [NI];
  logic        bl  [NI];
  logic        bld [NI];
  logic        hso [NI];
  logic        vso [NI];
  logic        fs  [NI];
  logic [15:0] fc  [NI];

  int hv [NI] = '{SHV, SHV, SHV, SHV, 640};
  int hf [NI] = '{SHF, SHF, SHF, SHF, 16};
  int hsw[NI] = '{SHS, SHS, SHS, SHS, 96};
  int hb [NI] = '{SHB, SHB, SHB, SHB, 48};
  int vv [NI] = '{SVV, SVV, SVV, SVV, 480};
  int vf [NI] = '{SVF, SVF, SVF, SVF, 10};
  int vsw[NI] = '{SVS, SVS, SVS, SVS, 2};
  int vb [NI] = '{SVB, SVB, SVB, SVB, 33};
  int lat[NI] = '{0, 1, 2, 7, 2};
  int off[NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(.H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
                   .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
                   .PIXEL_LATENCY(0)) u0 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx[0]), .DrawY(dy[0]),
    .blank(bl[0]), .blank_d(bld[0]), .hs(hso[0]), .vs(vso[0]),
    .frame_start(fs[0]), .frame_count(fc[0]));

  vga_timing_gen #(.H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
                   .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
                   .PIXEL_LATENCY(1)) u1 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx[1]), .DrawY(dy[1]),
    .blank(bl[1]), .blank_d(bld[1]), .hs(hso[1]), .vs(vso[1]),
    .frame_start(fs[1]), .frame_count(fc[1]));

  vga_timing_gen #(.H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
                   .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
                   .PIXEL_LATENCY(2)) u2 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx[2]), .DrawY(dy[2]),
    .blank(bl[2]), .blank_d(bld[2]), .hs(hso[2]), .vs(vso[2]),
    .frame_start(fs[2]), .frame_count(fc[2]));

  vga_timing_gen #(.H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
                   .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
                   .PIXEL_LATENCY(7)) u3 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx[3]), .DrawY(dy[3]),
    .blank(bl[3]), .blank_d(bld[3]), .hs(hso[3]), .vs(vso[3]),
    .frame_start(fs[3]), .frame_count(fc[3]));

  vga_timing_gen #(.PIXEL_LATENCY(2)) u4 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx[4]), .DrawY(dy[4]),
    .blank(bl[4]), .blank_d(bld[4]), .hs(hso[4]), .vs(vso[4]),
    .frame_start(fs[4]), .frame_count(fc[4]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int h_tot(input int i);
    return hv[i] + hf[i] + hsw[i] + hb[i];
  endfunction

  function automatic int v_tot(input int i);
    return vv[i] + vf[i] + vsw[i] + vb[i];
  endfunction

  // {hs, vs, blank} decoded from raster position after s edges; s<0 is the idle value
  function automatic logic [2:0] raw_at(input int i, input int s);
    int h, v;
    logic hsr, vsr, b;
    if (s < 0) return 3'b110;
    h   = s % h_tot(i);
    v   = (s / h_tot(i)) % v_tot(i);
    hsr = !((h >= hv[i] + hf[i]) && (h < hv[i] + hf[i] + hsw[i]));
    vsr = !((v >= vv[i] + vf[i]) && (v < vv[i] + vf[i] + vsw[i]));
    b   = (h < hv[i]) && (v < vv[i]);
    return {hsr, vsr, b};
  endfunction

  task automatic check_all(input int t, input bit in_reset);
    int eh, ev, efc;
    bit efs, ebl;
    logic [2:0] edl;
    for (int i = 0; i < NI; i++) begin
      if (in_reset) begin
        eh = 0; ev = 0; efc = 0; efs = 0; ebl = 1;
        edl = (lat[i] == 0) ? 3'b111 : 3'b110;
      end else begin
        eh  = t % h_tot(i);
        ev  = (t / h_tot(i)) % v_tot(i);
        efc = (off[i] + t / (h_tot(i) * v_tot(i))) & 32'hFFFF;
        efs = (eh == 0) && (ev == 0);
        ebl = raw_at(i, t)[0];
        edl = raw_at(i, t - lat[i]);
      end
      check_val($sformatf("u%0d.DrawX t=%0d", i, t), {22'd0, dx[i]}, eh);
      check_val($sformatf("u%0d.DrawY t=%0d", i, t), {22'd0, dy[i]}, ev);
      check_val($sformatf("u%0d.blank t=%0d", i, t), {31'd0, bl[i]}, {31'd0, ebl});
      check_val($sformatf("u%0d.hs t=%0d", i, t), {31'd0, hso[i]}, {31'd0, edl[2]});
      check_val($sformatf("u%0d.vs t=%0d", i, t), {31'd0, vso[i]}, {31'd0, edl[1]});
      check_val($sformatf("u%0d.blank_d t=%0d", i, t), {31'd0, bld[i]}, {31'd0, edl[0]});
      check_val($sformatf("u%0d.frame_start t=%0d", i, t), {31'd0, fs[i]}, {31'd0, efs});
      check_val($sformatf("u%0d.frame_count t=%0d", i, t), {16'd0, fc[i]}, efc);
    end
  endtask

  task automatic release_reset();
    @(posedge vga_clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < NI; i++) off[i] = 0;
  endtask

  initial begin
    int t_rst, t_force, hold;
    reset_n = 1'b0;
    for (int i = 0; i < NI; i++) off[i] = 0;

    // Power-on reset held for 5 cycles
    repeat (5) begin
      @(negedge vga_clk);
      check_all(0, 1'b1);
    end
    release_reset();

    // Run into the fourth compact frame, then drop reset asynchronously mid-frame
    t_rst = 3 * 187 + int'($urandom_range(0, 186));
    for (int t = 0; t <= t_rst; t++) begin
      @(negedge vga_clk);
      check_all(t, 1'b0);
    end
    #($urandom_range(1, 4));
    reset_n = 1'b0;
    #1;
    check_all(0, 1'b1);
    hold = int'($urandom_range(1, 4));
    repeat (hold) begin
      @(negedge vga_clk);
      check_all(0, 1'b1);
    end
    release_reset();

    // Long run covering default line timing; frame counter preloaded to wrap
    t_force = int'($urandom_range(5, 150));
    for (int t = 0; t < 2000; t++) begin
      @(negedge vga_clk);
      check_all(t, 1'b0);
      if (t == t_force) begin
        #1;
        force u0.frame_cnt_q = 16'hFFFF;
        force u1.frame_cnt_q = 16'hFFFF;
        force u2.frame_cnt_q = 16'hFFFF;
        force u3.frame_cnt_q = 16'hFFFF;
        force u4.frame_cnt_q = 16'hFFFF;
        #1;
        release u0.frame_cnt_q;
        release u1.frame_cnt_q;
        release u2.frame_cnt_q;
        release u3.frame_cnt_q;
        release u4.frame_cnt_q;
        for (int i = 0; i < NI; i++)
          off[i] = 32'hFFFF - t / (h_tot(i) * v_tot(i));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
